// File: rtl/key_pkg.sv
// Shared types and key-code constants for the keypad event path.
// Consumed by the key event detector and the game-control logic.
package key_pkg;

  localparam int KEY_W = 4;

  localparam logic [KEY_W-1:0] KEY_NONE = 4'd0;
  localparam logic [KEY_W-1:0] KEY_MAX  = 4'd11;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_e;

endpackage

// File: rtl/key_event_detector.sv
// Debounces keypad press/release and emits one key_valid pulse per
// accepted keystroke, holding the accepted code until the next accept.
module key_event_detector
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic             clk_1mhz,
  input  logic             rst,
  input  logic             button_pressed,
  input  logic [KEY_W-1:0] button_value,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_value,
  output logic             key_held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic             valid_q, valid_d;
  logic [KEY_W-1:0] value_q, value_d;
  logic             held_q, held_d;

  logic act;
  logic same_cand;
  logic same_key;
  logic cnt_last;

  assign act       = button_pressed && (button_value != KEY_NONE);
  assign same_cand = (button_value == cand_q);
  assign same_key  = (button_value == value_q);
  assign cnt_last  = (cnt_q == CNT_LAST);

  always_ff @(posedge clk_1mhz or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= KEY_NONE;
      valid_q <= 1'b0;
      value_q <= KEY_NONE;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      valid_q <= valid_d;
      value_q <= value_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    unique case (state_q)
      IDLE: begin
        if (act) begin
          cand_d  = button_value;
          cnt_d   = '0;
          state_d = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (!act) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (!same_cand) begin
          cand_d = button_value;
          cnt_d  = '0;
        end else if (cnt_last) begin
          cnt_d   = '0;
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!(act && same_key)) begin
          cnt_d   = '0;
          state_d = RELEASE_DB;
        end
      end
      RELEASE_DB: begin
        if (act && same_key) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (act) begin
          cnt_d = '0;
        end else if (cnt_last) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered: compute their next values from the same edge.
  always_comb begin
    valid_d = 1'b0;
    value_d = value_q;
    held_d  = held_q;
    unique case (state_q)
      PRESS_DB: begin
        if (act && same_cand && cnt_last) begin
          valid_d = 1'b1;
          value_d = cand_q;
          held_d  = 1'b1;
        end
      end
      RELEASE_DB: begin
        if (!act && cnt_last) begin
          held_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign key_valid = valid_q;
  assign key_value = value_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_key_event_detector.sv
// Directed bench for key_event_detector with a timestamp-based
// reference model and literal checks on key timing points.
module tb_key_event_detector;

  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic       bp;
  logic [3:0] bv;
  logic       kv;
  logic [3:0] kval;
  logic       kh;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  key_event_detector #(
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk_1mhz      (clk),
    .rst           (rst),
    .button_pressed(bp),
    .button_value  (bv),
    .key_valid     (kv),
    .key_value     (kval),
    .key_held      (kh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a press is accepted once the same key has been seen at sample
  // index mark and still at mark+N; a release completes once the line has
  // been free of the held key from index mark through mark+N.
  int         cyc;
  int         mark;
  logic       m_held;
  logic       m_pend;
  logic       m_rel;
  logic [3:0] m_cand;
  logic [3:0] m_key;
  logic       exp_valid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc       = 0;
      mark      = 0;
      m_held    = 1'b0;
      m_pend    = 1'b0;
      m_rel     = 1'b0;
      m_cand    = 4'd0;
      m_key     = 4'd0;
      exp_valid = 1'b0;
    end else begin
      logic act;
      cyc++;
      act       = bp && (bv != 4'd0);
      exp_valid = 1'b0;
      if (!m_held) begin
        if (!act) begin
          m_pend = 1'b0;
        end else if (!m_pend || bv != m_cand) begin
          m_pend = 1'b1;
          m_cand = bv;
          mark   = cyc;
        end else if (cyc - mark == N) begin
          exp_valid = 1'b1;
          m_held    = 1'b1;
          m_key     = m_cand;
          m_pend    = 1'b0;
          m_rel     = 1'b0;
        end
      end else begin
        if (act && bv == m_key) begin
          m_rel = 1'b0;
        end else if (!m_rel || act) begin
          m_rel = 1'b1;
          mark  = cyc;
        end else if (cyc - mark == N) begin
          m_held = 1'b0;
          m_rel  = 1'b0;
        end
      end
    end
  end

  logic prev_kv = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (kv !== exp_valid || kval !== m_key || kh !== m_held) begin
        errors++;
        $display("FAIL model t=%0t dut v/val/h=%b/%0d/%b exp=%b/%0d/%b",
                 $time, kv, kval, kh, exp_valid, m_key, m_held);
      end
      checks++;
      if (prev_kv && kv) begin
        errors++;
        $display("FAIL double_pulse t=%0t got=1 exp=0", $time);
      end
      if (kv) pulses++;
      prev_kv = kv;
    end else begin
      prev_kv = 1'b0;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic p, input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      bp = p;
      bv = v;
      @(posedge clk);
      @(negedge clk);
    end
    #1;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", int'(kv), 0);
    chk("rst_value", int'(kval), 0);
    chk("rst_held", int'(kh), 0);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  int p0;

  initial begin
    rst = 1'b1;
    bp  = 1'b0;
    bv  = 4'd0;
    #1;
    chk("init_valid", int'(kv), 0);
    chk("init_value", int'(kval), 0);
    chk("init_held", int'(kh), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;

    // Clean press: pulse exactly after the fifth sampling edge
    bp = 1'b1;
    bv = 4'd5;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("clean_pulse", int'(kv), (i == N) ? 1 : 0);
      chk("clean_held", int'(kh), (i >= N) ? 1 : 0);
    end
    chk("clean_value", int'(kval), 5);
    bv = 4'd0;
    bp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("rel_held", int'(kh), (i < N) ? 1 : 0);
    end
    chk("rel_value_kept", int'(kval), 5);
    @(negedge clk);
    #1;

    // Pressed flag with code 0 is not a press
    p0 = pulses;
    drive(1'b1, 4'd0, 8);
    chk("zero_code_pulses", pulses - p0, 0);

    // Press bounce
    p0 = pulses;
    drive(1'b1, 4'd3, 2);
    drive(1'b0, 4'd0, 1);
    drive(1'b1, 4'd3, 8);
    chk("bounce_pulses", pulses - p0, 1);
    chk("bounce_value", int'(kval), 3);
    drive(1'b0, 4'd0, 6);

    // Code change during debounce
    p0 = pulses;
    drive(1'b1, 4'd7, 2);
    drive(1'b1, 4'd8, 8);
    chk("change_pulses", pulses - p0, 1);
    chk("change_value", int'(kval), 8);
    drive(1'b0, 4'd0, 6);

    // Release bounce
    p0 = pulses;
    drive(1'b1, 4'd2, 6);
    drive(1'b0, 4'd0, 2);
    drive(1'b1, 4'd2, 2);
    chk("rbounce_held_mid", int'(kh), 1);
    drive(1'b0, 4'd0, 6);
    chk("rbounce_pulses", pulses - p0, 1);
    chk("rbounce_held_end", int'(kh), 0);
    chk("rbounce_value", int'(kval), 2);

    // Key switch while held, then boundary code 11
    p0 = pulses;
    drive(1'b1, 4'd9, 6);
    drive(1'b1, 4'd10, 8);
    chk("switch_pulses", pulses - p0, 1);
    chk("switch_value", int'(kval), 9);
    chk("switch_held", int'(kh), 1);
    drive(1'b0, 4'd0, 4);
    chk("switch_rel_held", int'(kh), 0);
    drive(1'b1, 4'd11, 5);
    chk("max_pulses", pulses - p0, 2);
    chk("max_value", int'(kval), 11);
    drive(1'b0, 4'd0, 6);

    // Reset during press debounce
    drive(1'b1, 4'd6, 2);
    pulse_rst();
    p0 = pulses;
    drive(1'b1, 4'd6, N);
    chk("rst_pd_nopulse", pulses - p0, 0);
    drive(1'b1, 4'd6, 1);
    chk("rst_pd_pulse_now", int'(kv), 1);
    chk("rst_pd_value", int'(kval), 6);

    // Reset while held
    drive(1'b1, 4'd6, 2);
    pulse_rst();
    p0 = pulses;
    drive(1'b1, 4'd6, N);
    chk("rst_h_nopulse", pulses - p0, 0);
    drive(1'b1, 4'd6, 1);
    chk("rst_h_pulse_now", int'(kv), 1);
    drive(1'b0, 4'd0, 6);
    chk("final_held", int'(kh), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
